// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use, branch-operand and MDU-busy stall
// detection, redirect flush control, and saturating stall/flush statistics.
module hazard_ctrl #(
  parameter int MULT_LAT = 4,
  parameter int DIV_LAT  = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  ID_rs,
  input  logic [4:0]  ID_rt,
  input  logic        ID_uses_rs,
  input  logic        ID_uses_rt,
  input  logic        ID_Branch,
  input  logic        ID_Redirect,
  input  logic        ID_HiLo,
  input  logic        EX_MemRead,
  input  logic        EX_RegWrite,
  input  logic [4:0]  EX_Wr,
  input  logic        MEM_MemRead,
  input  logic [4:0]  MEM_Wr,
  input  logic        EX_MDU_start,
  input  logic        EX_MDU_div,
  output logic        PC_wen,
  output logic        IF_ID_wen,
  output logic        IF_ID_Flush,
  output logic        ID_EX_Flush,
  output logic        mdu_busy,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  localparam int MAX_LAT = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
  localparam int CNT_W   = (MAX_LAT < 1) ? 1 : $clog2(MAX_LAT + 1);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_LAT);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_LAT);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mdu_state_t;

  mdu_state_t       state_reg, state_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [15:0]      stall_cnt_reg, stall_cnt_next;
  logic [15:0]      flush_cnt_reg, flush_cnt_next;

  // Source operands of the ID instruction, indexed 0 = rs, 1 = rt.
  logic [4:0] src_reg [2];
  logic [1:0] src_use;
  logic [1:0] hit_ex, hit_mem;
  logic       match_ex, match_mem;
  logic       load_use, br_haz, mdu_haz, stall;

  assign src_reg[0] = ID_rs;
  assign src_reg[1] = ID_rt;
  assign src_use    = {ID_uses_rt, ID_uses_rs};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      assign hit_ex[gi]  = src_use[gi] && (EX_Wr == src_reg[gi]);
      assign hit_mem[gi] = src_use[gi] && (MEM_Wr == src_reg[gi]);
    end
  endgenerate

  // $0 is hardwired to zero, so a write to it never creates a dependency.
  assign match_ex  = (EX_Wr != 5'd0) && (|hit_ex);
  assign match_mem = (MEM_Wr != 5'd0) && (|hit_mem);

  assign load_use = EX_MemRead && EX_RegWrite && match_ex;
  assign br_haz   = ID_Branch && ((EX_RegWrite && match_ex) ||
                                  (MEM_MemRead && match_mem));
  assign mdu_haz  = mdu_busy && ID_HiLo;
  assign stall    = load_use || br_haz || mdu_haz;

  // A stalled branch has not resolved, so its redirect is not trusted yet.
  always_comb begin
    PC_wen      = 1'b1;
    IF_ID_wen   = 1'b1;
    ID_EX_Flush = 1'b0;
    IF_ID_Flush = ID_Redirect;
    if (stall) begin
      PC_wen      = 1'b0;
      IF_ID_wen   = 1'b0;
      ID_EX_Flush = 1'b1;
      IF_ID_Flush = 1'b0;
    end
  end

  // MDU tracker: a new op reloads the countdown ahead of any decrement.
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    if (EX_MDU_start) begin
      count_next = EX_MDU_div ? DIV_LOAD : MULT_LOAD;
      state_next = (count_next != '0) ? BUSY : IDLE;
    end else begin
      case (state_reg)
        BUSY: begin
          count_next = count_reg - 1'b1;
          if (count_next == '0) state_next = IDLE;
        end
        default: begin
          count_next = '0;
          state_next = IDLE;
        end
      endcase
    end
  end

  always_comb begin
    stall_cnt_next = stall_cnt_reg;
    flush_cnt_next = flush_cnt_reg;
    if (stall && (stall_cnt_reg != 16'hFFFF))
      stall_cnt_next = stall_cnt_reg + 16'd1;
    if (IF_ID_Flush && (flush_cnt_reg != 16'hFFFF))
      flush_cnt_next = flush_cnt_reg + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      count_reg     <= '0;
      stall_cnt_reg <= 16'd0;
      flush_cnt_reg <= 16'd0;
    end else begin
      state_reg     <= state_next;
      count_reg     <= count_next;
      stall_cnt_reg <= stall_cnt_next;
      flush_cnt_reg <= flush_cnt_next;
    end
  end

  assign mdu_busy  = (state_reg == BUSY);
  assign stall_cnt = stall_cnt_reg;
  assign flush_cnt = flush_cnt_reg;

endmodule
